// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller and the display mux.
package cpu_run_ctrl_pkg;

    localparam int unsigned StateW = 2;

    // Encoding 3 is unused; the controller treats it as idle.
    typedef enum logic [StateW-1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StBreak = 2'd2
    } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_rise_detect.sv
// Single-bit registered rising-edge detector.
module cpu_run_ctrl_rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // Keep last cycle's level; a held input produces only one rise.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer: issues one-cycle CPU clock enables in step, free-run
// and run-until-breakpoint modes, and counts the pulses issued.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned RunDiv = 2500000,
    parameter int unsigned DivW   = 24,
    parameter int unsigned CntW   = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              step_btn_i,
    input  logic              run_sw_i,
    input  logic              break_en_i,
    input  logic [31:0]       break_pc_i,
    input  logic [31:0]       pc_i,
    output logic              cpu_ce_o,
    output logic              halted_o,
    output logic [StateW-1:0] state_o,
    output logic [CntW-1:0]   step_count_o
);

    localparam logic [DivW-1:0] DivLast = DivW'(RunDiv - 1);

    run_state_e      state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic            ce_q, ce_d;
    logic            halted_q, halted_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            step_rise;
    logic            break_hit;

    cpu_run_ctrl_rise_detect u_step_rise (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (step_btn_i),
        .rise_o (step_rise)
    );

    // Compare only right after a retired step, so the PC has just advanced.
    assign break_hit = ce_q & break_en_i & (pc_i == break_pc_i);

    // Next-state, divider and pulse decisions.
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        ce_d    = 1'b0;
        case (state_q)
            StRun: begin
                if (!run_sw_i) begin
                    state_d = StIdle;
                end else if (break_hit) begin
                    state_d = StBreak;
                end else if (div_q == DivLast) begin
                    ce_d = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StBreak: begin
                if (!run_sw_i) begin
                    state_d = StIdle;
                end else if (step_rise) begin
                    ce_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                if (run_sw_i) begin
                    state_d = StRun;
                end else if (step_rise) begin
                    ce_d = 1'b1;
                end
            end
        endcase
        halted_d = (state_d == StBreak);
        cnt_d    = cnt_q + CntW'(ce_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            div_q    <= '0;
            ce_q     <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            ce_q     <= ce_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cpu_ce_o     = ce_q;
    assign halted_o     = halted_q;
    assign state_o      = state_q;
    assign step_count_o = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a divide-by-4 run rate.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        step_btn;
    logic        run_sw;
    logic        break_en;
    logic [31:0] break_pc;
    logic [31:0] pc;
    logic        cpu_ce;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] step_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .RunDiv (4),
        .DivW   (24),
        .CntW   (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .step_btn_i   (step_btn),
        .run_sw_i     (run_sw),
        .break_en_i   (break_en),
        .break_pc_i   (break_pc),
        .pc_i         (pc),
        .cpu_ce_o     (cpu_ce),
        .halted_o     (halted),
        .state_o      (state),
        .step_count_o (step_count)
    );

    // Advance past a rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        step_btn = 1'b0;
        run_sw   = 1'b0;
        break_en = 1'b0;
        break_pc = 32'h0;
        pc       = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; step_btn = 1'b1; run_sw = 1'b1; break_en = 1'b0;
        break_pc = 32'h0; pc = 32'h0;
        tick(); tick(); tick();
        rst_n = 1'b0; step_btn = 1'b0; run_sw = 1'b0;
        tick();
        total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL reset_ce got=%b exp=0", cpu_ce); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++;
        if (step_count !== 16'h0) begin
            bad++; $display("FAIL reset_count got=%0d exp=0", step_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_step();
        int pulses = 0;
        int first  = -1;
        do_reset();
        step_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_ce === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL step_pulses got=%0d exp=1", pulses); end
        total++; if (first != 0) begin bad++; $display("FAIL step_latency got=%0d exp=0", first); end
        total++; if (step_count !== 16'd1) begin bad++; $display("FAIL step_count got=%0d exp=1", step_count); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL step_state got=%0d exp=0", state); end
        step_btn = 1'b0;
        tick();
    endtask

    task automatic test_free_run();
        logic exp_ce;
        do_reset();
        run_sw = 1'b1;
        tick();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL run_entry got=%0d exp=1", state); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_ce = (k % 4 == 0);
            total++;
            if (cpu_ce !== exp_ce) begin
                bad++; $display("FAIL run_ce cycle=%0d got=%b exp=%b", k, cpu_ce, exp_ce);
            end
        end
        run_sw = 1'b0;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL run_exit got=%0d exp=0", state); end
        total++; if (step_count !== 16'd5) begin bad++; $display("FAIL run_count got=%0d exp=5", step_count); end
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL run_after_ce got=%b exp=0", cpu_ce); end
        end
    endtask

    // Leaves the controller halted for test_step_in_break.
    task automatic test_breakpoint();
        int pulses    = 0;
        int brk_cycle = -1;
        int late      = 0;
        do_reset();
        break_en = 1'b1;
        break_pc = 32'h0000_000C;
        pc       = 32'h0;
        run_sw   = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (state === 2'd2 && brk_cycle < 0) brk_cycle = k;
            if (cpu_ce === 1'b1) begin
                pulses++;
                if (brk_cycle >= 0) late++;
                pc = pc + 32'd4;
            end
        end
        total++; if (pulses != 3) begin bad++; $display("FAIL brk_pulses got=%0d exp=3", pulses); end
        total++; if (brk_cycle != 13) begin bad++; $display("FAIL brk_cycle got=%0d exp=13", brk_cycle); end
        total++; if (late != 0) begin bad++; $display("FAIL brk_late_pulses got=%0d exp=0", late); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL brk_halted got=%b exp=1", halted); end
        total++; if (state !== 2'd2) begin bad++; $display("FAIL brk_state got=%0d exp=2", state); end
    endtask

    task automatic test_step_in_break();
        int pulses = 0;
        step_btn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_ce === 1'b1) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL bstep_pulses got=%0d exp=1", pulses); end
        total++; if (state !== 2'd2) begin bad++; $display("FAIL bstep_state got=%0d exp=2", state); end
        step_btn = 1'b0;
        tick();
        run_sw = 1'b0;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL bexit_state got=%0d exp=0", state); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL bexit_halted got=%b exp=0", halted); end
    endtask

    task automatic test_simultaneous();
        logic exp_ce;
        do_reset();
        step_btn = 1'b1;
        run_sw   = 1'b1;
        tick();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL simul_state got=%0d exp=1", state); end
        total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL simul_ce0 got=%b exp=0", cpu_ce); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_ce = (k == 4);
            total++;
            if (cpu_ce !== exp_ce) begin
                bad++; $display("FAIL simul_ce cycle=%0d got=%b exp=%b", k, cpu_ce, exp_ce);
            end
        end
        step_btn = 1'b0;
        run_sw   = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        run_sw = 1'b1;
        tick();
        for (int k = 1; k <= 7; k++) tick();
        total++; if (step_count !== 16'd1) begin bad++; $display("FAIL mid_pre_count got=%0d exp=1", step_count); end
        // Next edge is a divider-terminal edge.
        rst_n = 1'b0;
        tick();
        total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL mid_ce got=%b exp=0", cpu_ce); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL mid_state got=%0d exp=0", state); end
        total++; if (step_count !== 16'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", step_count); end
        rst_n  = 1'b1;
        run_sw = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        step_btn = 1'b1;
        tick();
        total++; if (step_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre got=%h exp=ffff", step_count); end
        tick();
        total++; if (step_count !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h exp=0000", step_count); end
        step_btn = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_free_run();
        test_breakpoint();
        test_step_in_break();
        test_simultaneous();
        test_reset_mid_run();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Execution sequencer for the multi-cycle CPU on the board test layer.
- Replaces the gated button clock with a one-cycle clock-enable pulse (cpu_ce) in the 25 MHz domain.
- Modes: single-step (debounced button), free-run at a divided rate, run-until-PC-breakpoint.
- Exposes halt status and a retired-step counter for the 7-seg display mux.

Parameters:
- RUN_DIV, 2500000, system cycles per cpu_ce pulse in RUN/free-run (10 Hz at 25 MHz); legal range 1..2^DIV_W-1.
- DIV_W, 24, divider counter width.
- CNT_W, 16, step counter width.

Ports:
- clk  in  1  system clock (25 MHz domain)
- rst  in  1  reset; synchronous, active-low
- step_btn  in  1  debounced step button, level
- run_sw  in  1  run switch, level; 1 = run requested
- break_en  in  1  enable PC breakpoint compare
- break_pc  in  32  breakpoint address
- pc  in  32  current CPU PC
- cpu_ce  out  1  registered one-cycle CPU clock enable
- halted  out  1  1 while in BREAK state
- state  out  2  current state encoding, for display/debug
- step_count  out  CNT_W  number of cpu_ce pulses issued

Behaviour:
- Reset (rst=0 at a rising clk edge):
  - state=IDLE, cpu_ce=0, halted=0, step_count=0, divider=0, step_btn history=0.
  - Applies from any state, including mid-RUN; a pending pulse is dropped.
- Step edge:
  - step_rise = step_btn & ~step_btn_q (step_btn_q registered every cycle).
  - Holding the button yields exactly one rise.
- States (2-bit encoding): IDLE=0, RUN=1, BREAK=2; 3 unused, decodes to IDLE.
- IDLE:
  - run_sw=1 -> RUN, divider<=0, cpu_ce<=0.
  - Else if step_rise -> cpu_ce<=1 for exactly one cycle, stay IDLE.
  - run_sw=1 and step_rise in the same cycle: run wins, step discarded.
- RUN:
  - run_sw=0 -> IDLE, divider<=0, cpu_ce<=0; precedes all other RUN actions.
  - Otherwise, if divider==RUN_DIV-1: divider<=0, cpu_ce<=1. Else divider<=divider+1, cpu_ce<=0.
  - First pulse is high during the RUN_DIV-th cycle after the IDLE->RUN edge; thereafter 1 pulse per RUN_DIV cycles.
  - RUN_DIV=1 gives cpu_ce high every cycle.
  - step_rise is ignored.
- Breakpoint:
  - Evaluated in RUN only, at the clk edge following a cycle in which cpu_ce=1, using the pc sampled at that edge.
  - If break_en=1 and pc==break_pc: state<=BREAK, halted<=1, cpu_ce<=0. This overrides a divider-terminal pulse on the same edge.
  - run_sw=0 on the same edge takes priority: go to IDLE, no halt.
- BREAK:
  - Divider held at 0.
  - step_rise -> one cpu_ce pulse, stay in BREAK; no compare.
  - run_sw=0 -> IDLE, halted<=0.
  - run_sw stays 1 -> remain halted; re-arming requires run_sw 1->0->1.
- step_count:
  - Increments on every edge where cpu_ce=1.
  - Wraps 2^CNT_W-1 -> 0.
- cpu_ce is never high for two consecutive cycles unless RUN_DIV=1.
- Outputs change only on clk edges; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_RUN, ST_BREAK) and the 2-bit state width, reused by the display mux.
- One natural sub-module: rise_detect, a single-bit registered rising-edge detector with synchronous active-low reset; used for step_btn.
- Divider, FSM and counter stay in cpu_run_ctrl.

Test Plan (RUN_DIV=4, CNT_W=16):
- Single step:
  - Stimulus: reset, run_sw=0, hold step_btn high 10 cycles.
  - Required: exactly one cpu_ce pulse, 1 cycle wide, one cycle after the rise; step_count=1; state=0.
- Free run:
  - Stimulus: run_sw=1 for 20 cycles, then 0.
  - Required: cpu_ce high in cycles 4, 8, 12, 16, 20 after entry; step_count=5; state returns to 0 the edge after run_sw falls; no further pulses.
- Breakpoint:
  - Stimulus: break_en=1, break_pc=0x0000000C, pc model advances by 4 per cpu_ce from 0.
  - Required: after the 3rd pulse, state=2 and halted=1 on the next edge; no 4th pulse while run_sw stays 1.
- Step in BREAK:
  - Stimulus: from the halt above, press step.
  - Required: one pulse, state stays 2; run_sw=0 -> state=0, halted=0.
- Priority / simultaneous:
  - Stimulus: in IDLE, step rise and run_sw rise on the same edge.
  - Required: RUN entered, no step pulse; first pulse 4 cycles later.
- Reset and wrap:
  - Stimulus: assert rst=0 mid-RUN on a divider-terminal edge.
  - Required: cpu_ce=0, state=0, step_count=0 next cycle.
  - Stimulus: force step_count to 0xFFFF, issue one step.
  - Required: step_count=0x0000.
